// File: rtl/wb_reg_file_if.sv
// Register-file access bundle: one write port and two asynchronous read ports.
// The datapath side drives the master modport; the register file takes the slave modport.
interface wb_reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b
  );
endinterface

// File: rtl/wb_reg_file.sv
// Architectural GPR file: one synchronous write port and two combinational read ports.
// Register 0 reads as zero; optional same-cycle write-to-read forwarding.
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  wb_reg_file_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_live;
  logic              fwd_a;
  logic              fwd_b;

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_live) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Forwarding is suppressed during reset so readers see stored contents.
  always_comb begin
    wr_live = bus.wr_en && (bus.wr_addr != '0);
    fwd_a   = (BYPASS != 0) && !reset && wr_live && (bus.wr_addr == bus.rd_addr_a);
    fwd_b   = (BYPASS != 0) && !reset && wr_live && (bus.wr_addr == bus.rd_addr_b);
  end

  always_comb begin
    bus.rd_data_a = '0;
    if (bus.rd_addr_a != '0) begin
      bus.rd_data_a = fwd_a ? bus.wr_data : mem[bus.rd_addr_a];
    end
  end

  always_comb begin
    bus.rd_data_b = '0;
    if (bus.rd_addr_b != '0) begin
      bus.rd_data_b = fwd_b ? bus.wr_data : mem[bus.rd_addr_b];
    end
  end
endmodule

// File: tb/tb_wb_reg_file.sv
// Bench for wb_reg_file: forwarding and non-forwarding instances share one stimulus
// stream and are checked against an array model of the architectural registers.
module tb_wb_reg_file;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;

  int compares = 0;
  int fails    = 0;

  logic [31:0] ref_mem [32];

  wb_reg_file_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
  wb_reg_file_if #(.DATA_W(32), .ADDR_W(5)) if0 ();

  assign if1.wr_en     = wr_en;
  assign if1.wr_addr   = wr_addr;
  assign if1.wr_data   = wr_data;
  assign if1.rd_addr_a = rd_addr_a;
  assign if1.rd_addr_b = rd_addr_b;
  assign if0.wr_en     = wr_en;
  assign if0.wr_addr   = wr_addr;
  assign if0.wr_data   = wr_data;
  assign if0.rd_addr_a = rd_addr_a;
  assign if0.rd_addr_b = rd_addr_b;

  wb_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  wb_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value, straight from the architectural rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && !reset && wr_en && wr_addr == a) return wr_data;
    return ref_mem[a];
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_b1_a"}, if1.rd_data_a, exp_rd(rd_addr_a, 1'b1));
    check({tag, "_b1_b"}, if1.rd_data_b, exp_rd(rd_addr_b, 1'b1));
    check({tag, "_b0_a"}, if0.rd_data_a, exp_rd(rd_addr_a, 1'b0));
    check({tag, "_b0_b"}, if0.rd_data_b, exp_rd(rd_addr_b, 1'b0));
  endtask

  // Advance one edge, update the model with the stimulus seen at that edge,
  // then step off the edge so new inputs and samples never race it.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    end else if (wr_en && wr_addr != 5'd0) begin
      ref_mem[wr_addr] = wr_data;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 'x;
    cycle();
    reset = 1'b0;
    rd_addr_a = 5'd1; rd_addr_b = 5'd31;
    #1;
    check("rst_b1_a", if1.rd_data_a, 32'h0);
    check("rst_b1_b", if1.rd_data_b, 32'h0);
    check("rst_b0_a", if0.rd_data_a, 32'h0);
    check("rst_b0_b", if0.rd_data_b, 32'h0);

    // Reset beats a simultaneous write; no forwarding while reset is high.
    write_reg(5'd5, 32'hDEADBEEF);
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678;
    rd_addr_a = 5'd5;
    #1;
    check("rst_nofwd_b1", if1.rd_data_a, 32'hDEADBEEF);
    check("rst_nofwd_b0", if0.rd_data_a, 32'hDEADBEEF);
    cycle();
    reset = 1'b0; wr_en = 1'b0;
    #1;
    check("rst_wins_b1", if1.rd_data_a, 32'h0);
    check("rst_wins_b0", if0.rd_data_a, 32'h0);

    write_reg(5'd31, 32'h0040_0010);
    write_reg(5'd8,  32'hFFFF_FFFF);
    rd_addr_a = 5'd31; rd_addr_b = 5'd8;
    #1;
    check("rw_r31_b1", if1.rd_data_a, 32'h0040_0010);
    check("rw_r8_b1",  if1.rd_data_b, 32'hFFFF_FFFF);
    check("rw_r31_b0", if0.rd_data_a, 32'h0040_0010);
    check("rw_r8_b0",  if0.rd_data_b, 32'hFFFF_FFFF);
    rd_addr_b = 5'd9;
    #1;
    check("rw_r9_b1", if1.rd_data_b, 32'h0);
    check("rw_r9_b0", if0.rd_data_b, 32'h0);

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hA5A5A5A5; rd_addr_a = 5'd0;
    #1;
    check("r0_pre_b1", if1.rd_data_a, 32'h0);
    check("r0_pre_b0", if0.rd_data_a, 32'h0);
    cycle();
    wr_en = 1'b0;
    #1;
    check("r0_post_b1", if1.rd_data_a, 32'h0);
    check("r0_post_b0", if0.rd_data_a, 32'h0);

    write_reg(5'd3, 32'h11);
    wr_en = 1'b0; wr_addr = 5'd3; wr_data = 32'h22; rd_addr_a = 5'd3;
    repeat (3) cycle();
    check("gate_b1", if1.rd_data_a, 32'h11);
    check("gate_b0", if0.rd_data_a, 32'h11);

    write_reg(5'd7, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h2; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    #1;
    check("byp_pre_b1_a", if1.rd_data_a, 32'h2);
    check("byp_pre_b1_b", if1.rd_data_b, 32'h2);
    check("byp_pre_b0_a", if0.rd_data_a, 32'h1);
    check("byp_pre_b0_b", if0.rd_data_b, 32'h1);
    cycle();
    wr_en = 1'b0;
    #1;
    check("byp_post_b1_a", if1.rd_data_a, 32'h2);
    check("byp_post_b1_b", if1.rd_data_b, 32'h2);
    check("byp_post_b0_a", if0.rd_data_a, 32'h2);
    check("byp_post_b0_b", if0.rd_data_b, 32'h2);

    // Random traffic; reads are steered onto the write address often enough
    // to exercise forwarding on each port and on both at once.
    for (int n = 0; n < 1000; n++) begin
      reset     = ($urandom_range(0, 49) == 0);
      wr_en     = $urandom_range(0, 3) != 0;
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      check_model("rnd");
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
